// File: rtl/ase_sim_avmm_credit_pkg.sv
// Shared command type and widths for the ASE Avalon-MM credit bridge.
// Struct field widths follow the default bus geometry; the bridge is built with these widths.
package ase_sim_avmm_credit_pkg;

    localparam int DATA_W          = 512;
    localparam int ADDR_W          = 27;
    localparam int BCNT_W          = 7;
    localparam int SYM_W           = 8;
    localparam int BE_W            = DATA_W / SYM_W;
    localparam int DEF_MAX_RD_BEATS = 256;
    localparam int CNT_W           = $clog2(DEF_MAX_RD_BEATS + 1);

    typedef struct packed {
        logic              read;
        logic              write;
        logic [ADDR_W-1:0] address;
        logic [BCNT_W-1:0] burstcount;
        logic [DATA_W-1:0] writedata;
        logic [BE_W-1:0]   byteenable;
    } t_cmd;

endpackage

// File: rtl/ase_sim_avmm_skid_buf.sv
// Two-entry fully registered skid buffer for t_cmd beats (main + skid).
// Latency 1 cycle; in_rdy_o is a flop, low while the skid entry is occupied and for one cycle after reset.
module ase_sim_avmm_skid_buf
    import ase_sim_avmm_credit_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_vld_i,
    input  t_cmd in_dat_i,
    output logic in_rdy_o,
    output logic out_vld_o,
    output t_cmd out_dat_o,
    input  logic out_rdy_i
);

    t_cmd main_q, main_d;
    t_cmd skid_q, skid_d;
    logic main_vld_q, main_vld_d;
    logic skid_vld_q, skid_vld_d;
    logic rdy_q, rdy_d;
    logic live_q;
    logic acc;
    logic main_free;

    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        acc        = in_vld_i & rdy_q;
        main_free  = !main_vld_q | out_rdy_i;

        if (main_free) begin
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = acc;
                if (acc) begin
                    main_d = in_dat_i;
                end
            end
        end

        // rdy_q low whenever skid is full, so an accept with main blocked always lands in an empty skid
        if (acc && !main_free) begin
            skid_d     = in_dat_i;
            skid_vld_d = 1'b1;
        end

        rdy_d = live_q & !skid_vld_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b0;
            live_q     <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
            live_q     <= 1'b1;
        end
    end

    assign in_rdy_o  = rdy_q;
    assign out_vld_o = main_vld_q;
    assign out_dat_o = main_q;

endmodule

// File: rtl/ase_sim_avmm_credit_bridge.sv
// Registered Avalon-MM stage between local-memory host (s0) and DDR emulator (m0) with read-beat credit gating.
// Command latency 1 cycle via skid buffer; read responses registered 1 cycle with no backpressure.
module ase_sim_avmm_credit_bridge
    import ase_sim_avmm_credit_pkg::*;
#(
    parameter int DATA_WIDTH          = DATA_W,
    parameter int ADDR_WIDTH          = ADDR_W,
    parameter int BURST_CNT_WIDTH     = BCNT_W,
    parameter int MASKED_SYMBOL_WIDTH = SYM_W,
    parameter int MAX_RD_BEATS        = DEF_MAX_RD_BEATS
) (
    input  logic                                      clk,
    input  logic                                      reset,
    output logic                                      s0_waitrequest,
    input  logic                                      s0_read,
    input  logic                                      s0_write,
    input  logic [ADDR_WIDTH-1:0]                     s0_address,
    input  logic [BURST_CNT_WIDTH-1:0]                s0_burstcount,
    input  logic [DATA_WIDTH-1:0]                     s0_writedata,
    input  logic [DATA_WIDTH/MASKED_SYMBOL_WIDTH-1:0] s0_byteenable,
    output logic [DATA_WIDTH-1:0]                     s0_readdata,
    output logic                                      s0_readdatavalid,
    input  logic                                      m0_waitrequest,
    output logic                                      m0_read,
    output logic                                      m0_write,
    output logic [ADDR_WIDTH-1:0]                     m0_address,
    output logic [BURST_CNT_WIDTH-1:0]                m0_burstcount,
    output logic [DATA_WIDTH-1:0]                     m0_writedata,
    output logic [DATA_WIDTH/MASKED_SYMBOL_WIDTH-1:0] m0_byteenable,
    input  logic [DATA_WIDTH-1:0]                     m0_readdata,
    input  logic                                      m0_readdatavalid,
    output logic [$clog2(MAX_RD_BEATS+1)-1:0]         rd_beats_outstanding
);

    localparam int              CW           = $clog2(MAX_RD_BEATS + 1);
    localparam logic [CW:0]     CREDIT_LIMIT = (CW+1)'(MAX_RD_BEATS);
    localparam logic [CW-1:0]   ONE_BEAT     = CW'(1);

    t_cmd s0_cmd;
    t_cmd main_cmd;
    logic s0_vld;
    logic s0_rdy;
    logic main_vld;
    logic main_rdy;
    logic credit_ok;
    logic rd_acc;
    logic [CW:0]   rd_need;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic                  rdv_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_comb begin
        s0_cmd            = '0;
        s0_cmd.read       = s0_read;
        s0_cmd.write      = s0_write;
        s0_cmd.address    = s0_address;
        s0_cmd.burstcount = s0_burstcount;
        s0_cmd.writedata  = s0_writedata;
        s0_cmd.byteenable = s0_byteenable;
    end

    assign s0_vld         = s0_read | s0_write;
    assign s0_waitrequest = !s0_rdy;

    ase_sim_avmm_skid_buf u_skid (
        .clk_i     (clk),
        .rst_i     (reset),
        .in_vld_i  (s0_vld),
        .in_dat_i  (s0_cmd),
        .in_rdy_o  (s0_rdy),
        .out_vld_o (main_vld),
        .out_dat_o (main_cmd),
        .out_rdy_i (main_rdy)
    );

    // A read holds in main until its whole burst fits under the outstanding-beat limit.
    assign rd_need   = {1'b0, cnt_q} + (CW+1)'(main_cmd.burstcount);
    assign credit_ok = rd_need <= CREDIT_LIMIT;

    assign m0_read       = main_vld & main_cmd.read & credit_ok;
    assign m0_write      = main_vld & main_cmd.write;
    assign m0_address    = main_cmd.address;
    assign m0_burstcount = main_cmd.burstcount;
    assign m0_writedata  = main_cmd.writedata;
    assign m0_byteenable = main_cmd.byteenable;

    assign main_rdy = (m0_read | m0_write) & !m0_waitrequest;
    assign rd_acc   = m0_read & !m0_waitrequest;

    // Gating guarantees cnt_q + burst never exceeds the limit, so the add cannot wrap.
    always_comb begin
        cnt_inc = rd_acc ? CW'(main_cmd.burstcount) : '0;
        cnt_d   = cnt_q + cnt_inc;
        if (m0_readdatavalid && (cnt_d != '0)) begin
            cnt_d = cnt_d - ONE_BEAT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            rdv_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            rdv_q   <= m0_readdatavalid;
            rdata_q <= m0_readdata;
        end
    end

    assign rd_beats_outstanding = cnt_q;
    assign s0_readdatavalid     = rdv_q;
    assign s0_readdata          = rdata_q;

endmodule

// File: tb/tb_ase_sim_avmm_credit_bridge.sv
// Directed bench for the credit bridge: command-order scoreboard, outstanding-beat model and response pipe
// checked every cycle at the falling edge, plus literal expectations per scenario.
module tb_ase_sim_avmm_credit_bridge;

    localparam int DW  = 512;
    localparam int AW  = 27;
    localparam int BW  = 7;
    localparam int BEW = 64;
    localparam int MAX = 128;
    localparam int CW  = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           s0_waitrequest;
    logic           s0_read, s0_write;
    logic [AW-1:0]  s0_address;
    logic [BW-1:0]  s0_burstcount;
    logic [DW-1:0]  s0_writedata;
    logic [BEW-1:0] s0_byteenable;
    logic [DW-1:0]  s0_readdata;
    logic           s0_readdatavalid;
    logic           m0_waitrequest;
    logic           m0_read, m0_write;
    logic [AW-1:0]  m0_address;
    logic [BW-1:0]  m0_burstcount;
    logic [DW-1:0]  m0_writedata;
    logic [BEW-1:0] m0_byteenable;
    logic [DW-1:0]  m0_readdata;
    logic           m0_readdatavalid;
    logic [CW-1:0]  rd_beats_outstanding;

    ase_sim_avmm_credit_bridge #(.MAX_RD_BEATS(MAX)) dut (
        .clk                  (clk),
        .reset                (reset),
        .s0_waitrequest       (s0_waitrequest),
        .s0_read              (s0_read),
        .s0_write             (s0_write),
        .s0_address           (s0_address),
        .s0_burstcount        (s0_burstcount),
        .s0_writedata         (s0_writedata),
        .s0_byteenable        (s0_byteenable),
        .s0_readdata          (s0_readdata),
        .s0_readdatavalid     (s0_readdatavalid),
        .m0_waitrequest       (m0_waitrequest),
        .m0_read              (m0_read),
        .m0_write             (m0_write),
        .m0_address           (m0_address),
        .m0_burstcount        (m0_burstcount),
        .m0_writedata         (m0_writedata),
        .m0_byteenable        (m0_byteenable),
        .m0_readdata          (m0_readdata),
        .m0_readdatavalid     (m0_readdatavalid),
        .rd_beats_outstanding (rd_beats_outstanding)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit             rd;
        bit             wr;
        logic [AW-1:0]  a;
        logic [BW-1:0]  b;
        logic [DW-1:0]  d;
        logic [BEW-1:0] be;
    } cmd_t;

    cmd_t           q[$];
    int             mcnt = 0;
    bit             exp_rdv = 1'b0;
    logic [DW-1:0]  exp_rdata = '0;
    int             hold = 0;
    int             m0_acc_cnt = 0;
    int             s0_rdv_cnt = 0;

    always @(negedge clk) begin : mon
        bit   e_rd, e_wr, e_wq;
        cmd_t c;
        if (reset) begin
            chk("rst_waitreq", s0_waitrequest, 1);
            chk("rst_m0_read", m0_read, 0);
            chk("rst_m0_write", m0_write, 0);
            chk("rst_s0_rdv", s0_readdatavalid, 0);
            chk("rst_cnt", rd_beats_outstanding, 0);
            q.delete();
            mcnt      = 0;
            exp_rdv   = 1'b0;
            exp_rdata = '0;
            hold      = 2;
        end else begin
            e_wq = (hold > 0) || (q.size() >= 2);
            e_rd = (q.size() > 0) && q[0].rd && (mcnt + int'(q[0].b) <= MAX);
            e_wr = (q.size() > 0) && q[0].wr;
            chk("s0_waitrequest", s0_waitrequest, e_wq);
            chk("m0_read", m0_read, e_rd);
            chk("m0_write", m0_write, e_wr);
            if (e_rd || e_wr) begin
                chk("m0_address", m0_address, q[0].a);
                chk("m0_burstcount", m0_burstcount, q[0].b);
                chk("m0_writedata", m0_writedata, q[0].d);
                chk("m0_byteenable", m0_byteenable, q[0].be);
            end
            chk("rd_beats_outstanding", rd_beats_outstanding, mcnt[CW-1:0]);
            chk("s0_readdatavalid", s0_readdatavalid, exp_rdv);
            if (exp_rdv) chk("s0_readdata", s0_readdata, exp_rdata);
            if (s0_readdatavalid) s0_rdv_cnt++;

            // Events taking effect at the coming rising edge.
            if ((e_rd || e_wr) && !m0_waitrequest) begin
                if (e_rd) mcnt += int'(q[0].b);
                void'(q.pop_front());
                m0_acc_cnt++;
            end
            if (m0_readdatavalid && mcnt > 0) mcnt--;
            exp_rdv   = m0_readdatavalid;
            exp_rdata = m0_readdata;
            if ((s0_read || s0_write) && !e_wq) begin
                c.rd = s0_read; c.wr = s0_write; c.a = s0_address; c.b = s0_burstcount;
                c.d = s0_writedata; c.be = s0_byteenable;
                q.push_back(c);
            end
            if (hold > 0) hold--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] pat(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 ^ 32'(i);
        return {16{w}};
    endfunction

    function automatic logic [BEW-1:0] bpat(input int i);
        logic [7:0] w;
        w = 8'(i * 37 + 5);
        return {8{w}};
    endfunction

    task automatic send(input bit rd, input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] b,
                        input logic [DW-1:0] d, input logic [BEW-1:0] be, output bit ok);
        s0_read = rd; s0_write = wr; s0_address = a; s0_burstcount = b;
        s0_writedata = d; s0_byteenable = be;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (reset) break;
            if (!s0_waitrequest) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) tick();
        else if (!reset) chk("send_timeout", ok, 1);
        s0_read = 1'b0; s0_write = 1'b0;
    endtask

    task automatic wburst(input logic [AW-1:0] a, input int n);
        bit ok;
        for (int i = 0; i < n; i++) begin
            send(0, 1, a, BW'(n), pat(100 + i), bpat(i), ok);
            if (!ok) break;
        end
    endtask

    bit ok;

    initial begin
        reset = 1'b1;
        s0_read = 0; s0_write = 0; s0_address = '0; s0_burstcount = '0;
        s0_writedata = '0; s0_byteenable = '0;
        m0_waitrequest = 1'b0; m0_readdatavalid = 1'b0; m0_readdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_waitreq", s0_waitrequest, 1);
        chk("init_m0_address", m0_address, 0);
        chk("init_cnt", rd_beats_outstanding, 0);
        reset = 1'b0;
        #1 chk("post_rst_waitreq", s0_waitrequest, 1);
        tick();

        // 1: single read of 4, responses at latency 10
        s0_rdv_cnt = 0;
        send(1, 0, 27'h100, 7'd4, '0, '1, ok);
        tick();
        chk("t1_cnt_issue", rd_beats_outstanding, 4);
        repeat (9) tick();
        for (int i = 0; i < 4; i++) begin
            m0_readdatavalid = 1'b1;
            m0_readdata = pat(i);
            tick();
            chk("t1_cnt_dec", rd_beats_outstanding, CW'(3 - i));
        end
        m0_readdatavalid = 1'b0;
        tick();
        chk("t1_rdv_count", s0_rdv_cnt, 4);

        // 2: back-to-back 64-beat reads against a 128-beat limit
        m0_acc_cnt = 0;
        fork
            begin
                send(1, 0, 27'h1000, 7'd64, '0, '1, ok);
                send(1, 0, 27'h2000, 7'd64, '0, '1, ok);
                send(1, 0, 27'h3000, 7'd64, '0, '1, ok);
                send(1, 0, 27'h4000, 7'd64, '0, '1, ok);
            end
        join
        repeat (8) tick();
        chk("t2_issued", m0_acc_cnt, 2);
        chk("t2_cnt_full", rd_beats_outstanding, 128);
        chk("t2_m0_read_held", m0_read, 0);
        chk("t2_waitreq_full", s0_waitrequest, 1);
        m0_readdatavalid = 1'b1;
        for (int i = 0; i < 63; i++) begin
            m0_readdata = pat(200 + i);
            tick();
        end
        chk("t2_cnt_65", rd_beats_outstanding, 65);
        chk("t2_still_held", m0_read, 0);
        m0_readdata = pat(263);
        tick();
        chk("t2_cnt_64", rd_beats_outstanding, 64);
        chk("t2_release", m0_read, 1);
        for (int i = 0; i < 192; i++) begin
            m0_readdata = pat(300 + i);
            tick();
        end
        m0_readdatavalid = 1'b0;
        repeat (3) tick();
        chk("t2_drained", rd_beats_outstanding, 0);
        chk("t2_all_issued", m0_acc_cnt, 4);

        // 3: write burst of 8 with m0 backpressure toggling
        m0_acc_cnt = 0;
        fork
            wburst(27'h200, 8);
            begin
                for (int k = 0; k < 40; k++) begin
                    m0_waitrequest = k[0];
                    tick();
                end
                m0_waitrequest = 1'b0;
            end
        join
        repeat (3) tick();
        chk("t3_write_beats", m0_acc_cnt, 8);

        // 4: read issued on the same edge a response beat arrives
        send(1, 0, 27'h500, 7'd5, '0, '1, ok);
        tick();
        chk("t4_cnt_5", rd_beats_outstanding, 5);
        m0_waitrequest = 1'b1;
        send(1, 0, 27'h600, 7'd2, '0, '1, ok);
        chk("t4_presented", m0_read, 1);
        m0_waitrequest = 1'b0;
        m0_readdatavalid = 1'b1;
        m0_readdata = pat(700);
        tick();
        chk("t4_cnt_6", rd_beats_outstanding, 6);
        repeat (6) tick();
        m0_readdatavalid = 1'b0;
        tick();
        chk("t4_cnt_0", rd_beats_outstanding, 0);

        // 5: reset in the middle of a 16-beat write
        send(1, 0, 27'h700, 7'd3, '0, '1, ok);
        tick();
        chk("t5_cnt_3", rd_beats_outstanding, 3);
        m0_waitrequest = 1'b1;
        fork
            wburst(27'h800, 16);
            begin
                repeat (5) tick();
                chk("t5_m0_write_pre", m0_write, 1);
                reset = 1'b1;
                #1;
                chk("t5_m0_write_rst", m0_write, 0);
                chk("t5_cnt_rst", rd_beats_outstanding, 0);
                chk("t5_waitreq_rst", s0_waitrequest, 1);
                repeat (3) tick();
                reset = 1'b0;
                m0_waitrequest = 1'b0;
                #1 chk("t5_waitreq_post", s0_waitrequest, 1);
            end
        join
        s0_rdv_cnt = 0;
        send(1, 0, 27'h900, 7'd2, '0, '1, ok);
        tick();
        chk("t5_cnt_2", rd_beats_outstanding, 2);
        m0_readdatavalid = 1'b1;
        m0_readdata = pat(900);
        tick();
        m0_readdata = pat(901);
        tick();
        m0_readdatavalid = 1'b0;
        tick();
        chk("t5_rdv_count", s0_rdv_cnt, 2);
        chk("t5_cnt_0", rd_beats_outstanding, 0);

        // 6: stray response with nothing outstanding
        m0_readdatavalid = 1'b1;
        m0_readdata = pat(999);
        tick();
        m0_readdatavalid = 1'b0;
        chk("t6_cnt_0", rd_beats_outstanding, 0);
        chk("t6_rdv", s0_readdatavalid, 1);
        chk("t6_rdata", s0_readdata, pat(999));
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ase_sim_avmm_credit_bridge.md
Name: ase_sim_avmm_credit_bridge

Overview:
- Registered Avalon-MM pipeline stage between the burst-mapped local-memory interface (s0, host/AFU side) and the simulated DDR emulator (m0).
- Isolates the DUT from emulator timing glitches with a fully registered command skid buffer and a registered read-response path.
- Throttles read commands so outstanding read beats never exceed a configured credit limit.

Parameters:
- DATA_WIDTH, 512, data bus width in bits.
- ADDR_WIDTH, 27, word address width.
- BURST_CNT_WIDTH, 7, burstcount width; max burst = 2^(BURST_CNT_WIDTH-1).
- MASKED_SYMBOL_WIDTH, 8, bits per byteenable lane.
- MAX_RD_BEATS, 256, read-beat credit limit; must be >= 2^(BURST_CNT_WIDTH-1).

Ports:
- clk  in  1  single clock for both sides.
- reset  in  1  asynchronous, active-high reset.
- s0_waitrequest  out  1  command backpressure to source.
- s0_read / s0_write  in  1  command strobes, mutually exclusive.
- s0_address  in  ADDR_WIDTH  word address.
- s0_burstcount  in  BURST_CNT_WIDTH  beats in burst.
- s0_writedata  in  DATA_WIDTH  write data.
- s0_byteenable  in  DATA_WIDTH/MASKED_SYMBOL_WIDTH  byte lanes.
- s0_readdata  out  DATA_WIDTH  read data.
- s0_readdatavalid  out  1  read beat valid.
- m0_waitrequest  in  1  emulator backpressure.
- m0_read / m0_write, m0_address, m0_burstcount, m0_writedata, m0_byteenable  out  same widths as s0  command to emulator.
- m0_readdata  in  DATA_WIDTH; m0_readdatavalid  in  1  emulator response.
- rd_beats_outstanding  out  $clog2(MAX_RD_BEATS+1)  current credit usage (debug).

Behaviour:
- Reset values (asynchronous): s0_waitrequest=1; m0_read=m0_write=0; s0_readdatavalid=0; all data/address regs=0; counter=0; both skid entries invalid.
- Command path: 2-entry skid (main + skid).
  - s0 beat accepted when (s0_read|s0_write) & !s0_waitrequest.
  - s0_waitrequest is registered: 1 while skid entry valid or during reset; 0 otherwise.
  - Accepted beat goes to main if main is empty or draining this cycle, else to skid.
  - m0 presents main; main drains when (m0_read|m0_write) & !m0_waitrequest; skid moves to main on the same edge.
  - Minimum latency: beat accepted at edge N is visible on m0 after edge N.
  - Full throughput when m0_waitrequest=0 and no read gating.
- Read credit gate: main holding a read with burstcount B is presented (m0_read=1) only if rd_beats_outstanding + B <= MAX_RD_BEATS; otherwise m0_read=0 and main holds. Commands never reorder.
- Write bursts: every beat passes ungated; the burst continues uninterrupted; the gate evaluates only read commands.
- Counter update per cycle:
  - m0 read accepted only: +B.
  - m0_readdatavalid only: -1.
  - Both in the same cycle: +B-1.
  - Saturates at 0; a stray readdatavalid after reset does not underflow.
- Response path: s0_readdata/s0_readdatavalid = m0 values registered 1 cycle; no backpressure, no drop, no reorder.
- Reset mid-burst: all queued commands discarded, counter cleared; s0_waitrequest=1 for at least one cycle after reset deasserts.

Decomposition:
- Package ase_sim_avmm_credit_pkg:
  - t_cmd struct (read, write, address, burstcount, writedata, byteenable).
  - Localparams for byteenable width and counter width.
- Sub-module ase_sim_avmm_skid_buf: generic 2-entry registered skid buffer on t_cmd with valid/ready handshake.
- Top level contains the credit gate, counter and response register.

Test Plan:
- Single read, burstcount 4, m0 returns 4 beats at latency 10 -> s0_readdatavalid pulses 4 times, each 1 cycle after m0; counter reads 4 then 3, 2, 1, 0.
- Back-to-back 64-beat reads with MAX_RD_BEATS=128 and no responses -> first 2 reads issue; third holds m0_read=0 and s0_waitrequest rises after skid fills; first response beat releases nothing until counter <= 64.
- Write burst of 8 with m0_waitrequest toggling 1/0 -> m0 sees 8 beats in order with identical data/byteenable; s0_waitrequest never asserted with both entries empty.
- Read issued to m0 in the same cycle as a response beat arrives (B=2, counter=5) -> counter becomes 6.
- Reset asserted mid 16-beat write, then released -> m0_write=0 at once, counter=0, s0_waitrequest=1 during reset, new read completes normally.
- Stray m0_readdatavalid with counter=0 -> counter stays 0; beat forwarded to s0.
